// File: rtl/branch_sequencer.sv
// PC sequencer and pipeline-flush controller for the 4-bit core.
// Optional taken/stall statistics counters are enabled with `define BRANCH_SEQ_STATS_EN.
//
// state | meaning
// IDLE  | one cycle after reset release, fetch still off
// RUN   | normal sequential fetch, honours halt/branch/stall
// FLUSH | fetching from branch target while squashing wrong-path instructions
// HALT  | fetch stopped, waits for resume
module branch_sequencer #(
  parameter int BUS          = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           br_valid,
  input  logic           br_nop,
  input  logic [BUS-1:0] jump_address,
  input  logic           stall,
  input  logic           halt_req,
  input  logic           resume,
  output logic [BUS-1:0] pc,
  output logic           fetch_en,
  output logic           flush,
  output logic           halted
`ifdef BRANCH_SEQ_STATS_EN
  ,
  output logic [7:0]     taken_cnt,
  output logic [7:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

  state_t     state;
  logic [2:0] flush_cnt;
  logic       taken;

  assign taken = br_valid & ~br_nop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      fetch_en  <= 1'b0;
      flush     <= 1'b0;
      halted    <= 1'b0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= RUN;
          fetch_en <= 1'b1;
        end
        RUN: begin
          if (halt_req) begin
            state    <= HALT;
            fetch_en <= 1'b0;
            halted   <= 1'b1;
          end else if (taken) begin
            state     <= FLUSH;
            pc        <= jump_address;
            fetch_en  <= 1'b1;
            flush     <= 1'b1;
            flush_cnt <= 3'(FLUSH_CYCLES - 1);
          end else if (stall) begin
            fetch_en <= 1'b0;
          end else begin
            pc       <= pc + BUS'(1);
            fetch_en <= 1'b1;
          end
        end
        FLUSH: begin
          // Branches and stalls here belong to squashed instructions.
          pc       <= pc + BUS'(1);
          fetch_en <= 1'b1;
          if (flush_cnt == 3'd0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        HALT: begin
          if (resume) begin
            state    <= RUN;
            halted   <= 1'b0;
            fetch_en <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          fetch_en <= 1'b0;
          flush    <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_SEQ_STATS_EN
  logic run_taken;
  logic run_stall;

  assign run_taken = (state == RUN) & ~halt_req & taken;
  assign run_stall = (state == RUN) & ~halt_req & ~taken & stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (run_taken && taken_cnt != 8'hFF) taken_cnt <= taken_cnt + 8'd1;
      if (run_stall && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_branch_sequencer;
  localparam int BUS = 4;
  localparam int FC  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           br_valid = 1'b0, br_nop = 1'b0, stall = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [BUS-1:0] jump_address = '0;
  logic [BUS-1:0] pc;
  logic           fetch_en, flush, halted;
`ifdef BRANCH_SEQ_STATS_EN
  logic [7:0]     taken_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  branch_sequencer #(.BUS(BUS), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_nop(br_nop),
    .jump_address(jump_address), .stall(stall), .halt_req(halt_req), .resume(resume),
    .pc(pc), .fetch_en(fetch_en), .flush(flush), .halted(halted)
`ifdef BRANCH_SEQ_STATS_EN
    , .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: mode names as strings, flush tracked as cycles remaining.
  string m_mode;
  int    m_pc;
  bit    m_fe, m_h;
  int    m_flush_left;
  int    m_taken, m_stalls;

  function automatic bit m_flush();
    return m_mode == "flush";
  endfunction

  function automatic void model_reset();
    m_mode = "idle"; m_pc = 0; m_fe = 0; m_h = 0; m_flush_left = 0;
    m_taken = 0; m_stalls = 0;
  endfunction

  function automatic void model_clock(bit v, bit nop, int ja, bit st, bit hr, bit rs);
    if (m_mode == "idle") begin
      m_mode = "run"; m_fe = 1;
    end else if (m_mode == "run") begin
      if (hr) begin
        m_mode = "halt"; m_fe = 0; m_h = 1;
      end else if (v && !nop) begin
        m_mode = "flush"; m_pc = ja; m_fe = 1; m_flush_left = FC;
        if (m_taken < 255) m_taken++;
      end else if (st) begin
        m_fe = 0;
        if (m_stalls < 255) m_stalls++;
      end else begin
        m_pc = (m_pc + 1) % (1 << BUS); m_fe = 1;
      end
    end else if (m_mode == "flush") begin
      m_pc = (m_pc + 1) % (1 << BUS); m_fe = 1;
      m_flush_left--;
      if (m_flush_left == 0) m_mode = "run";
    end else if (m_mode == "halt") begin
      if (rs) begin
        m_mode = "run"; m_h = 0; m_fe = 1;
      end
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pc", int'(pc), m_pc);
    chk("fetch_en", int'(fetch_en), int'(m_fe));
    chk("flush", int'(flush), int'(m_flush()));
    chk("halted", int'(halted), int'(m_h));
`ifdef BRANCH_SEQ_STATS_EN
    chk("taken_cnt", int'(taken_cnt), m_taken);
    chk("stall_cnt", int'(stall_cnt), m_stalls);
`endif
  endtask

  // Called at a falling edge: apply inputs, advance model, compare at next falling edge.
  task automatic step(bit v, bit nop, int ja, bit st, bit hr, bit rs);
    br_valid = v; br_nop = nop; jump_address = BUS'(ja);
    stall = st; halt_req = hr; resume = rs;
    model_clock(v, nop, ja, st, hr, rs);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("reset_pc", int'(pc), 0);
    chk("reset_fetch_en", int'(fetch_en), 0);
    repeat (cycles) begin
      @(negedge clk);
      compare_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Boot: one IDLE cycle, then pc 0,1,2,3 with fetch enabled.
    idle_step();
    chk("boot_pc0", int'(pc), 0);
    chk("boot_fe", int'(fetch_en), 1);
    idle_step(); idle_step(); idle_step();
    chk("boot_pc3", int'(pc), 3);

    // Taken branch at pc=3 to 4'hA.
    step(1, 0, 'hA, 0, 0, 0);
    chk("br_target", int'(pc), 'hA);
    chk("br_flush1", int'(flush), 1);
    idle_step();
    chk("br_pcB", int'(pc), 'hB);
    chk("br_flush2", int'(flush), 1);
    idle_step();
    chk("br_pcC", int'(pc), 'hC);
    chk("br_flush_end", int'(flush), 0);

    // Not taken at pc=F wraps to 0.
    repeat (3) idle_step();
    chk("pre_wrap", int'(pc), 'hF);
    step(1, 1, 'h7, 0, 0, 0);
    chk("wrap_pc", int'(pc), 0);
    chk("wrap_flush", int'(flush), 0);

    // Stall at pc=5 for three cycles, then stall with a taken branch.
    repeat (5) idle_step();
    repeat (3) begin
      step(0, 0, 0, 1, 0, 0);
      chk("stall_pc", int'(pc), 5);
      chk("stall_fe", int'(fetch_en), 0);
    end
    step(1, 0, 2, 1, 0, 0);
    chk("stall_br_pc", int'(pc), 2);
    chk("stall_br_flush", int'(flush), 1);

    // Halt requested mid-flush waits for the flush to finish.
    step(0, 0, 0, 0, 1, 0);
    chk("halt_defer", int'(halted), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("halt_defer_run", int'(halted), 0);
    chk("halt_defer_pc", int'(pc), 4);
    step(0, 0, 0, 0, 1, 0);
    chk("halt_on", int'(halted), 1);
    repeat (4) begin
      step(1, 0, 9, 1, 0, 0);
      chk("halt_frozen", int'(pc), 4);
    end
    step(0, 0, 0, 0, 1, 1);
    chk("resume_halted", int'(halted), 0);
    idle_step();
    chk("resume_pc", int'(pc), 5);

    // Reset asserted mid-flush.
    step(1, 0, 9, 0, 0, 0);
    chk("pre_rst_flush", int'(flush), 1);
    do_reset(2);
    chk("rst_flush", int'(flush), 0);
    chk("rst_pc", int'(pc), 0);

`ifdef BRANCH_SEQ_STATS_EN
    idle_step();
    repeat (5) step(0, 0, 0, 1, 0, 0);
    chk("stall_cnt5", int'(stall_cnt), 5);
    repeat (300) begin
      step(1, 0, $urandom_range(15), 0, 0, 0);
      repeat (FC) idle_step();
    end
    chk("taken_sat", int'(taken_cnt), 'hFF);
    do_reset(1);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        do_reset($urandom_range(2));
      end else begin
        step($urandom_range(9) < 3, $urandom_range(1) == 1, $urandom_range(15),
             $urandom_range(4) == 0, $urandom_range(19) == 0, $urandom_range(2) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Program-counter sequencer and pipeline-flush controller for the 4-bit processor core.
- Owns the PC register and drives the fetch enable.
- Consumes the branch unit's decision (jump address plus NOP/not-taken flag) and redirects fetch when a branch is taken.
- Squashes wrong-path instructions by asserting flush for a fixed number of cycles; also handles decode stalls and halt/resume.

Parameters:
- BUS, 4, width of PC and jump address.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch (legal range 1..7).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- br_valid  input  1  decode stage holds a branch instruction this cycle; qualifies br_nop and jump_address.
- br_nop  input  1  branch unit NOP output; 1 = condition false / not taken, 0 = taken.
- jump_address  input  BUS  branch unit target address.
- stall  input  1  decode hazard; hold PC.
- halt_req  input  1  request to stop fetching.
- resume  input  1  leave HALT.
- pc  output  BUS  current fetch address.
- fetch_en  output  1  instruction memory read enable.
- flush  output  1  pipeline registers load NOP.
- halted  output  1  high while in HALT.

Behaviour:
- All outputs registered. On rst_n=0, immediately and asynchronously: state=IDLE, pc=0, fetch_en=0, flush=0, halted=0, flush counter=0.
- Reset asserted mid-operation (any state, mid-flush) aborts everything and returns to these values.
- States: IDLE, RUN, FLUSH, HALT.
- IDLE: first clock after reset release goes to RUN, fetch_en=1, pc stays 0.
- RUN priority per cycle, highest first:
  - halt_req: HALT; fetch_en=0; halted=1; pc held.
  - br_valid & !br_nop: pc<=jump_address; flush=1; counter<=FLUSH_CYCLES-1; go to FLUSH. Taken branch overrides a simultaneous stall.
  - stall: pc held, fetch_en=0.
  - otherwise: pc<=pc+1, fetch_en=1.
- Taken-branch latency: target appears on pc one cycle after the br_valid cycle.
- br_valid & br_nop (not taken) is treated as a normal increment.
- FLUSH:
  - flush=1 and fetch_en=1; pc increments each cycle from the target, so fetch runs from the target.
  - br_valid is ignored here, since those instructions are squashed.
  - stall is ignored here.
  - counter decrements each cycle; when counter==0, next state is RUN with flush=0.
  - flush is high for exactly FLUSH_CYCLES consecutive cycles.
  - halt_req during FLUSH is held off until flush completes; it is then honoured in RUN if still asserted.
- HALT: fetch_en=0, flush=0, halted=1, pc frozen. resume=1 moves to RUN next cycle, halted=0. resume is ignored outside HALT. halt_req and resume both high in HALT: resume wins.
- Arithmetic: pc+1 wraps modulo 2^BUS (4'hF -> 4'h0). jump_address is taken verbatim, no offset added.

Optional Feature:
- Macro BRANCH_SEQ_STATS_EN.
- When defined, adds two outputs:
  - taken_cnt [7:0]: increments on each accepted taken branch.
  - stall_cnt [7:0]: increments on each RUN cycle held by stall.
  - Both saturate at 8'hFF and reset to 0 on rst_n=0.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset/boot: rst_n low 3 cycles, then high -> pc=0, fetch_en=0 during reset; one IDLE cycle; then pc 0,1,2,3 on successive cycles with fetch_en=1.
- Taken branch: at pc=4'h3 drive br_valid=1, br_nop=0, jump_address=4'hA -> next cycle pc=4'hA; flush=1 for exactly 2 cycles (pc A, B); then pc=4'hC with flush=0.
- Not taken and wrap: br_valid=1, br_nop=1 at pc=4'hF -> pc=4'h0 next, flush stays 0.
- Stall vs branch: stall=1 for 3 cycles at pc=5 -> pc holds 5, fetch_en=0. stall=1 with a taken branch to 4'h2 -> pc=2, flush=1.
- Halt/resume: halt_req during FLUSH -> waits until flush ends, then halted=1, pc frozen for 4 cycles. resume=1 -> RUN, pc increments from the frozen value. Asserting rst_n low mid-FLUSH -> immediate pc=0, flush=0.
- Stats (BRANCH_SEQ_STATS_EN): 300 taken branches -> taken_cnt=8'hFF (saturated); 5 stall cycles -> stall_cnt=5.
